// File: rtl/defs_pkg.sv
// defs_pkg: shared opcode definitions for the execute-stage alu
package defs_pkg;
   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_SLL = 3'd5,
      ALU_SRL = 3'd6,
      ALU_SLT = 3'd7
   } alu_opcode_t;
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: unsigned shift-add multiplier that sequences the shared alu, with overflow flag
module alu_mul_seq
   import defs_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic [WIDTH-1:0] alu_in1,
   output logic [WIDTH-1:0] alu_in2,
   output alu_opcode_t      alu_op,
   input  logic [WIDTH-1:0] alu_out,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [WIDTH-1:0] result,
   output logic             result_ovf,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, result_q, result_d;
   logic             ovf_q, ovf_d, result_ovf_q, result_ovf_d;
   assign start_ready  = !rst && state_q == IDLE;
   assign busy         = state_q != IDLE;
   assign result_valid = state_q == DONE;
   assign result       = result_q;
   assign result_ovf   = result_ovf_q;
   assign alu_op       = ALU_ADD;
   assign alu_in1      = state_q == RUN ? acc_q : '0;
   assign alu_in2      = state_q == RUN ? mcand_q : '0;
   // next-state: accept, one add-and-shift step per RUN cycle, hold result until consumed
   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      mcand_d      = mcand_q;
      mplier_d     = mplier_q;
      ovf_d        = ovf_q;
      result_d     = result_q;
      result_ovf_d = result_ovf_q;
      if (state_q == IDLE && start_valid) begin
         acc_d    = '0;
         mcand_d  = op_a;
         mplier_d = op_b;
         ovf_d    = 1'b0;
         if (op_b == '0) begin
            result_d     = '0;
            result_ovf_d = 1'b0;
            state_d      = DONE;
         end else begin
            state_d = RUN;
         end
      end else if (state_q == RUN) begin
         acc_d    = mplier_q[0] ? alu_out : acc_q;
         ovf_d    = ovf_q | (mplier_q[0] && alu_out < acc_q) | (mcand_q[WIDTH-1] & |mplier_q[WIDTH-1:1]);
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         if (mplier_q[WIDTH-1:1] == '0) begin
            result_d     = acc_d;
            result_ovf_d = ovf_d;
            state_d      = DONE;
         end
      end else if (state_q == DONE && result_ready) begin
         state_d = IDLE;
      end
   end
   // state and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         acc_q        <= '0;
         mcand_q      <= '0;
         mplier_q     <= '0;
         ovf_q        <= 1'b0;
         result_q     <= '0;
         result_ovf_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         mcand_q      <= mcand_d;
         mplier_q     <= mplier_d;
         ovf_q        <= ovf_d;
         result_q     <= result_d;
         result_ovf_q <= result_ovf_d;
      end
   end
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: scoreboard bench for the sequential multiplier with a behavioural alu
module tb_alu_mul_seq;
   import defs_pkg::*;
   localparam int W = 8;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start_valid = 1'b0;
   logic         start_ready;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic [W-1:0] alu_in1, alu_in2, alu_out;
   alu_opcode_t  alu_op;
   logic         result_valid;
   logic         result_ready = 1'b1;
   logic [W-1:0] result;
   logic         result_ovf;
   logic         busy;
   typedef struct {
      logic [W-1:0] res;
      logic         ovf;
      int           runs;
   } exp_t;
   exp_t sb[$];
   int errors = 0;
   int checks = 0;
   alu_mul_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
      .op_a(op_a), .op_b(op_b), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
      .alu_out(alu_out), .result_valid(result_valid), .result_ready(result_ready),
      .result(result), .result_ovf(result_ovf), .busy(busy)
   );
   assign alu_out = alu_in1 + alu_in2;
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   always @(negedge clk) begin
      check("alu_op", 32'(alu_op), 32'(ALU_ADD));
      if (!busy) check("alu_in_idle", {alu_in1, alu_in2}, 32'd0);
   end
   task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
      exp_t        e;
      logic [15:0] p;
      int          n;
      n = 0;
      while (!start_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!start_ready) check("start_timeout", 0, 1);
      p = 16'(a) * 16'(b);
      e.res = p[7:0];
      e.ovf = |p[15:8];
      e.runs = 0;
      for (int i = 0; i < W; i++) if (b[i]) e.runs = i + 1;
      if (push) sb.push_back(e);
      start_valid = 1'b1;
      op_a = a;
      op_b = b;
      @(negedge clk);
      start_valid = 1'b0;
      op_a = W'($urandom);
      op_b = W'($urandom);
   endtask
   task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
      exp_t         e;
      int           runs, n;
      logic [W-1:0] r;
      logic         o;
      result_ready = (hold == 0);
      start(a, b, 1'b1);
      runs = 0;
      n = 0;
      while (!result_valid && n < 20) begin
         if (busy) runs++;
         n++;
         @(negedge clk);
      end
      if (!result_valid) begin
         check("valid_timeout", 0, 1);
         return;
      end
      e = sb.pop_front();
      check("run_cycles", runs, e.runs);
      check("result", 32'(result), 32'(e.res));
      check("ovf", 32'(result_ovf), 32'(e.ovf));
      r = result;
      o = result_ovf;
      for (int i = 0; i < hold; i++) begin
         start_valid = 1'b1;
         op_a = W'($urandom);
         op_b = W'($urandom);
         check("hold_start_ready", 32'(start_ready), 0);
         @(negedge clk);
         check("hold_valid", 32'(result_valid), 1);
         check("hold_result", {result_ovf, result}, {o, r});
      end
      start_valid = 1'b0;
      result_ready = 1'b1;
      @(negedge clk);
      check("valid_drop", 32'(result_valid), 0);
      check("idle_after", {busy, start_ready}, 32'b01);
   endtask
   initial begin
      repeat (3) @(negedge clk);
      check("rst_start_ready", 32'(start_ready), 0);
      check("rst_outs", {busy, result_valid, result_ovf, result}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_start_ready", 32'(start_ready), 1);
      run_one(8'h03, 8'h05, 0);
      run_one(8'h10, 8'h10, 0);
      run_one(8'hFF, 8'h00, 0);
      run_one(8'h0F, 8'h80, 0);
      run_one(8'hFF, 8'h01, 0);
      run_one(8'h0F, 8'h80, 5);
      run_one(8'hFF, 8'hFF, 0);
      start(8'h0F, 8'h80, 1'b0);
      @(negedge clk);
      @(negedge clk);
      check("abort_busy", 32'(busy), 1);
      rst = 1'b1;
      @(negedge clk);
      check("abort_outs", {busy, result_valid, start_ready, result_ovf, result}, 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("abort_no_valid", 32'(result_valid), 0);
      end
      check("abort_ready", 32'(start_ready), 1);
      for (int i = 0; i < 25; i++) run_one(W'($urandom), W'($urandom), $urandom_range(0, 2));
      check("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
